io_port_hub: RTL

IO_PORT_HUB -- requirements
Module: io_port_hub

---
 rtl/io_port_hub_pkg.sv | 18 +
 rtl/io_port_hub_btn_debounce.sv | 30 +++
 rtl/io_port_hub.sv | 106 ++++++++++
 3 files changed

// File: rtl/io_port_hub_pkg.sv
// io_port_hub_pkg: port address map and BCD iteration helper shared by the IO hub
package io_port_hub_pkg;
  localparam logic [15:0] PORT_IO_LED      = 16'h0000;
  localparam logic [15:0] PORT_IO_HEX      = 16'h0001;
  localparam logic [15:0] PORT_IO_DEC      = 16'h0002;
  localparam logic [15:0] PORT_IO_CHAR     = 16'h0003;
  localparam logic [15:0] PORT_IO_BITS     = 16'h0004;
  localparam logic [15:0] PORT_IO_SWITCH   = 16'h0005;
  localparam logic [15:0] PORT_IO_BUTTON   = 16'h0006;
  localparam logic [15:0] PORT_IO_BTN_EDGE = 16'h0007;
  localparam logic [15:0] PORT_IO_STATUS   = 16'h0008;
  function automatic logic [19:0] bcd_step(input logic [19:0] b, input logic bit_in);
    logic [19:0] a;
    a = b;
    for (int k = 0; k < 5; k++) a[4*k+:4] = b[4*k+:4] >= 4'd5 ? b[4*k+:4] + 4'd3 : b[4*k+:4];
    return {a[18:0], bit_in};
  endfunction
endpackage

// File: rtl/io_port_hub_btn_debounce.sv
// btn_debounce: one-channel 2-flop synchroniser plus stable-count debouncer
module btn_debounce #(
  parameter int CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = CYC > 2 ? $clog2(CYC) : 1;
  logic s1, s2;
  logic [CW-1:0] cnt;
  logic flip;
  assign flip = (s2 != level) && (cnt == CW'(CYC - 1));
  assign rise = flip && s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 != level && !flip) ? cnt + 1'b1 : '0;
      level <= flip ? s2 : level;
    end
  end
endmodule

// File: rtl/io_port_hub.sv
// io_port_hub: memory-mapped LED/seven-segment/switch/button port block with sequential BCD display
module io_port_hub
  import io_port_hub_pkg::*;
#(
  parameter int LED_W        = 4,
  parameter int SW_W         = 8,
  parameter int BTN_W        = 4,
  parameter int SSD_DIGITS   = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SW_W-1:0]         sw,
  input  logic [BTN_W-1:0]        btn,
  output logic [LED_W-1:0]        led,
  output logic [8*SSD_DIGITS-1:0] ssd_bits,
  output logic                    ssd_char_mode,
  input  logic                    port_read,
  input  logic                    port_write,
  input  logic [15:0]             port_addr,
  input  logic [15:0]             port_write_data,
  output logic [15:0]             port_read_data
);
  localparam int SSD_W = 8 * SSD_DIGITS;
  logic [BTN_W-1:0] level, rise, edge_reg;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [15:0] bin, rd_val;
  logic [19:0] bcd, bcd_nxt;
  logic [3:0] cnt;
  logic busy, done;
  logic wr_led, wr_hex, wr_dec, wr_char, wr_bits, rd_edge;
  logic [SSD_W-1:0] hex_disp, dec_disp, shifted;
  genvar i;
  for (i = 0; i < BTN_W; i++) begin : g_db
    btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk), .rst_n(rst_n), .raw(btn[i]), .level(level[i]), .rise(rise[i])
    );
  end
  assign wr_led  = port_write && port_addr == PORT_IO_LED;
  assign wr_hex  = port_write && port_addr == PORT_IO_HEX;
  assign wr_dec  = port_write && port_addr == PORT_IO_DEC;
  assign wr_char = port_write && port_addr == PORT_IO_CHAR;
  assign wr_bits = port_write && port_addr == PORT_IO_BITS;
  assign rd_edge = port_read && port_addr == PORT_IO_BTN_EDGE;
  assign bcd_nxt = bcd_step(bcd, bin[15]);
  assign done    = busy && cnt == 4'd15;
  assign shifted = {ssd_bits[SSD_W-17:0], port_write_data};
  always_comb begin
    hex_disp = '0;
    dec_disp = '0;
    for (int k = 0; k < 4; k++) hex_disp[8*k+:4] = port_write_data[4*k+:4];
    for (int k = 0; k < 5; k++) if (k < SSD_DIGITS) dec_disp[8*k+:4] = bcd_nxt[4*k+:4];
  end
  always_comb begin
    rd_val = port_addr == PORT_IO_LED      ? 16'(led)      :
             port_addr == PORT_IO_SWITCH   ? 16'(sw_s2)    :
             port_addr == PORT_IO_BUTTON   ? 16'(level)    :
             port_addr == PORT_IO_BTN_EDGE ? 16'(edge_reg) :
             port_addr == PORT_IO_STATUS   ? {15'b0, busy} : 16'h0000;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
      ssd_bits <= '1;
      ssd_char_mode <= 1'b0;
      port_read_data <= '0;
      edge_reg <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else begin
      led <= wr_led ? port_write_data[LED_W-1:0] : led;
      port_read_data <= port_read ? rd_val : '0;
      edge_reg <= (rd_edge ? '0 : edge_reg) | rise;
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      // a new DEC operand always wins; other display writes cancel a pending result
      if (wr_dec) begin
        bin <= port_write_data;
        bcd <= '0;
        cnt <= '0;
        busy <= 1'b1;
      end else if (wr_hex || wr_char || wr_bits) begin
        busy <= 1'b0;
      end else if (busy) begin
        bin <= bin << 1;
        bcd <= bcd_nxt;
        cnt <= cnt + 4'd1;
        busy <= !done;
      end
      if (wr_hex) begin
        ssd_bits <= hex_disp;
        ssd_char_mode <= 1'b1;
      end else if (wr_char || wr_bits) begin
        ssd_bits <= shifted;
        ssd_char_mode <= wr_char;
      end else if (done && !wr_dec) begin
        ssd_bits <= dec_disp;
        ssd_char_mode <= 1'b1;
      end
    end
  end
endmodule
